// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between requesters and the shared timer scheduler.
// abort_i exists only when TIMER_SCHED_ABORT_EN is defined.
interface timer_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
) ();
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*CNT_W-1:0] delay_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic                     tick_o;
`ifdef TIMER_SCHED_ABORT_EN
    logic                     abort_i;

    modport master (
        output req_i, delay_i, abort_i,
        input  grant_o, done_o, busy_o, tick_o
    );

    modport slave (
        input  req_i, delay_i, abort_i,
        output grant_o, done_o, busy_o, tick_o
    );
`else
    modport master (
        output req_i, delay_i,
        input  grant_o, done_o, busy_o, tick_o
    );

    modport slave (
        input  req_i, delay_i,
        output grant_o, done_o, busy_o, tick_o
    );
`endif
endinterface

// File: rtl/timer_scheduler.sv
// Single down-counting timer shared round-robin among NUM_REQ requesters.
// Optional abort of a running timer is enabled by defining TIMER_SCHED_ABORT_EN.
module timer_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;

    logic                 pick_vld_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic [IDX_W-1:0]     cand_c;
    logic [CNT_W-1:0]     dly_c [NUM_REQ];

    logic [NUM_REQ-1:0]   grant_d;
    logic [NUM_REQ-1:0]   done_d;
    logic                 busy_d;
    logic                 tick_d;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_dly
        assign dly_c[k] = bus.delay_i[k*CNT_W +: CNT_W];
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        cand_c     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_c = IDX_W'((32'(last_q) + i) % NUM_REQ);
            if (!pick_vld_c && bus.req_i[cand_c]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = cand_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;

        grant_d = gnt_q;
        done_d  = '0;
        busy_d  = (state_q != IDLE);
        tick_d  = bus.tick_o;

        unique case (state_q)
            IDLE: begin
                if (pick_vld_c) begin
                    state_d = COUNT;
                    cnt_d   = dly_c[pick_idx_c];
                    idx_d   = pick_idx_c;
                    gnt_d   = NUM_REQ'(1) << pick_idx_c;
                end
            end
            COUNT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`ifdef TIMER_SCHED_ABORT_EN
                // Abort overrides an expiry landing on the same edge
                if (bus.abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    last_d  = idx_q;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = idx_q;
                done_d  = gnt_q;
                tick_d  = ~bus.tick_o;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Visible outputs trail the internal state by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.grant_o <= '0;
            bus.done_o  <= '0;
            bus.busy_o  <= 1'b0;
            bus.tick_o  <= 1'b0;
        end else begin
            bus.grant_o <= grant_d;
            bus.done_o  <= done_d;
            bus.busy_o  <= busy_d;
            bus.tick_o  <= tick_d;
        end
    end
endmodule
